// File: rtl/r4_bfly_sched.sv
// Sequencer around one shared combinational radix-4 butterfly: gathers a,b,c,d, fetches twiddles, emits out0..out3.
// Optional BFLY_SCALE_EN: results are scaled by 1/4 (round-half-up) before emission.
module r4_bfly_sched #(
  parameter int N         = 64,
  parameter int LOG2N     = 6,
  parameter int TW_STRIDE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [31:0]      in_re,
  input  logic signed [31:0]      in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [31:0]      out_re,
  output logic signed [31:0]      out_im,
  output logic                    out_last,
  output logic                    tw_rd_en,
  output logic [LOG2N-1:0]        tw_addr0,
  output logic [LOG2N-1:0]        tw_addr1,
  output logic [LOG2N-1:0]        tw_addr2,
  input  logic signed [15:0]      tw0r,
  input  logic signed [15:0]      tw0i,
  input  logic signed [15:0]      tw1r,
  input  logic signed [15:0]      tw1i,
  input  logic signed [15:0]      tw2r,
  input  logic signed [15:0]      tw2i,
  output logic signed [31:0]      bf_ar,
  output logic signed [31:0]      bf_ai,
  output logic signed [31:0]      bf_br,
  output logic signed [31:0]      bf_bi,
  output logic signed [31:0]      bf_cr,
  output logic signed [31:0]      bf_ci,
  output logic signed [31:0]      bf_dr,
  output logic signed [31:0]      bf_di,
  output logic signed [15:0]      bf_w0r,
  output logic signed [15:0]      bf_w0i,
  output logic signed [15:0]      bf_w1r,
  output logic signed [15:0]      bf_w1i,
  output logic signed [15:0]      bf_w2r,
  output logic signed [15:0]      bf_w2i,
  input  logic signed [31:0]      bf_o0r,
  input  logic signed [31:0]      bf_o0i,
  input  logic signed [31:0]      bf_o1r,
  input  logic signed [31:0]      bf_o1i,
  input  logic signed [31:0]      bf_o2r,
  input  logic signed [31:0]      bf_o2i,
  input  logic signed [31:0]      bf_o3r,
  input  logic signed [31:0]      bf_o3i
);

  localparam int GW = LOG2N - 2;
  localparam logic [GW-1:0]    GMAX = GW'(N / 4 - 1);
  localparam logic [LOG2N-1:0] STR1 = LOG2N'(TW_STRIDE);
  localparam logic [LOG2N-1:0] STR2 = LOG2N'(2 * TW_STRIDE);
  localparam logic [LOG2N-1:0] STR3 = LOG2N'(3 * TW_STRIDE);

  typedef enum logic [1:0] {COLLECT, TWID, CALC, EMIT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [GW-1:0]   g_q, g_d;
  logic            accept, ld_w, ld_res;

  logic signed [31:0] op_re_q  [4];
  logic signed [31:0] op_im_q  [4];
  logic signed [15:0] w_re_q   [3];
  logic signed [15:0] w_im_q   [3];
  logic signed [31:0] res_re_q [4];
  logic signed [31:0] res_im_q [4];

  function automatic logic signed [31:0] scl(input logic signed [31:0] x);
`ifdef BFLY_SCALE_EN
    logic signed [32:0] t;
    logic signed [32:0] s;
    t = {x[31], x} + 33'sd2;
    s = t >>> 2;
    return s[31:0];
`else
    return x;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      idx_q   <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      g_q     <= g_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    g_d       = g_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    tw_rd_en  = 1'b0;
    accept    = 1'b0;
    ld_w      = 1'b0;
    ld_res    = 1'b0;
    case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            tw_rd_en = 1'b1;
            state_d  = TWID;
          end
        end
      end
      TWID: begin
        ld_w    = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        ld_res  = 1'b1;
        idx_d   = 2'd0;
        state_d = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_last  = (idx_q == 2'd3) && (g_q == GMAX);
        if (out_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            g_d     = (g_q == GMAX) ? '0 : g_q + 1'b1;
            state_d = COLLECT;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Operand slots double as the butterfly operand registers; they only move while collecting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        op_re_q[i]  <= '0;
        op_im_q[i]  <= '0;
        res_re_q[i] <= '0;
        res_im_q[i] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        w_re_q[i] <= '0;
        w_im_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        op_re_q[cnt_q] <= in_re;
        op_im_q[cnt_q] <= in_im;
      end
      if (ld_w) begin
        w_re_q[0] <= tw0r;
        w_im_q[0] <= tw0i;
        w_re_q[1] <= tw1r;
        w_im_q[1] <= tw1i;
        w_re_q[2] <= tw2r;
        w_im_q[2] <= tw2i;
      end
      if (ld_res) begin
        res_re_q[0] <= scl(bf_o0r);
        res_im_q[0] <= scl(bf_o0i);
        res_re_q[1] <= scl(bf_o1r);
        res_im_q[1] <= scl(bf_o1i);
        res_re_q[2] <= scl(bf_o2r);
        res_im_q[2] <= scl(bf_o2i);
        res_re_q[3] <= scl(bf_o3r);
        res_im_q[3] <= scl(bf_o3i);
      end
    end
  end

  // Address products wrap naturally in LOG2N bits, i.e. mod N.
  logic [LOG2N-1:0] gx;
  assign gx       = LOG2N'(g_q);
  assign tw_addr0 = gx * STR1;
  assign tw_addr1 = gx * STR2;
  assign tw_addr2 = gx * STR3;

  assign out_re = res_re_q[idx_q];
  assign out_im = res_im_q[idx_q];

  assign bf_ar  = op_re_q[0];
  assign bf_ai  = op_im_q[0];
  assign bf_br  = op_re_q[1];
  assign bf_bi  = op_im_q[1];
  assign bf_cr  = op_re_q[2];
  assign bf_ci  = op_im_q[2];
  assign bf_dr  = op_re_q[3];
  assign bf_di  = op_im_q[3];
  assign bf_w0r = w_re_q[0];
  assign bf_w0i = w_im_q[0];
  assign bf_w1r = w_re_q[1];
  assign bf_w1i = w_im_q[1];
  assign bf_w2r = w_re_q[2];
  assign bf_w2i = w_im_q[2];

endmodule

// File: tb/tb_r4_bfly_sched.sv
// Directed bench for r4_bfly_sched: ROM model, butterfly model, stride-1 and stride-2 instances.
module tb_r4_bfly_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, out_ready;
  logic signed [31:0] in_re, in_im;
  logic in_ready, out_valid, out_last, tw_rd_en;
  logic signed [31:0] out_re, out_im;
  logic [5:0] tw_addr0, tw_addr1, tw_addr2;
  logic signed [15:0] tw0r, tw0i, tw1r, tw1i, tw2r, tw2i;
  logic signed [31:0] bf_ar, bf_ai, bf_br, bf_bi, bf_cr, bf_ci, bf_dr, bf_di;
  logic signed [15:0] bf_w0r, bf_w0i, bf_w1r, bf_w1i, bf_w2r, bf_w2i;
  logic signed [31:0] bf_o0r, bf_o0i, bf_o1r, bf_o1i, bf_o2r, bf_o2i, bf_o3r, bf_o3i;

  // Second instance (TW_STRIDE = 2) shares all inputs; only its addresses are examined.
  logic d2_in_ready, d2_out_valid, d2_out_last, d2_tw_rd_en;
  logic signed [31:0] d2_out_re, d2_out_im;
  logic [5:0] d2_addr0, d2_addr1, d2_addr2;
  logic signed [31:0] d2_ar, d2_ai, d2_br, d2_bi, d2_cr, d2_ci, d2_dr, d2_di;
  logic signed [15:0] d2_w0r, d2_w0i, d2_w1r, d2_w1i, d2_w2r, d2_w2i;

  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;
  int n_last = 0;
  int got_re[4];
  int got_im[4];

  r4_bfly_sched #(.N(64), .LOG2N(6), .TW_STRIDE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_last(out_last), .tw_rd_en(tw_rd_en),
    .tw_addr0(tw_addr0), .tw_addr1(tw_addr1), .tw_addr2(tw_addr2),
    .tw0r(tw0r), .tw0i(tw0i), .tw1r(tw1r), .tw1i(tw1i), .tw2r(tw2r), .tw2i(tw2i),
    .bf_ar(bf_ar), .bf_ai(bf_ai), .bf_br(bf_br), .bf_bi(bf_bi),
    .bf_cr(bf_cr), .bf_ci(bf_ci), .bf_dr(bf_dr), .bf_di(bf_di),
    .bf_w0r(bf_w0r), .bf_w0i(bf_w0i), .bf_w1r(bf_w1r), .bf_w1i(bf_w1i),
    .bf_w2r(bf_w2r), .bf_w2i(bf_w2i),
    .bf_o0r(bf_o0r), .bf_o0i(bf_o0i), .bf_o1r(bf_o1r), .bf_o1i(bf_o1i),
    .bf_o2r(bf_o2r), .bf_o2i(bf_o2i), .bf_o3r(bf_o3r), .bf_o3i(bf_o3i)
  );

  r4_bfly_sched #(.N(64), .LOG2N(6), .TW_STRIDE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(d2_out_valid), .out_ready(out_ready),
    .out_re(d2_out_re), .out_im(d2_out_im), .out_last(d2_out_last), .tw_rd_en(d2_tw_rd_en),
    .tw_addr0(d2_addr0), .tw_addr1(d2_addr1), .tw_addr2(d2_addr2),
    .tw0r(tw0r), .tw0i(tw0i), .tw1r(tw1r), .tw1i(tw1i), .tw2r(tw2r), .tw2i(tw2i),
    .bf_ar(d2_ar), .bf_ai(d2_ai), .bf_br(d2_br), .bf_bi(d2_bi),
    .bf_cr(d2_cr), .bf_ci(d2_ci), .bf_dr(d2_dr), .bf_di(d2_di),
    .bf_w0r(d2_w0r), .bf_w0i(d2_w0i), .bf_w1r(d2_w1r), .bf_w1i(d2_w1i),
    .bf_w2r(d2_w2r), .bf_w2i(d2_w2i),
    .bf_o0r(bf_o0r), .bf_o0i(bf_o0i), .bf_o1r(bf_o1r), .bf_o1i(bf_o1i),
    .bf_o2r(bf_o2r), .bf_o2i(bf_o2i), .bf_o3r(bf_o3r), .bf_o3i(bf_o3i)
  );

  // Twiddle ROM: real part 32767, imaginary part echoes the address; junk when not read.
  always @(posedge clk) begin
    if (tw_rd_en) begin
      tw0r <= 16'sd32767; tw0i <= 16'(tw_addr0);
      tw1r <= 16'sd32767; tw1i <= 16'(tw_addr1);
      tw2r <= 16'sd32767; tw2i <= 16'(tw_addr2);
    end else begin
      tw0r <= 16'h5A5A; tw0i <= 16'h5A5A;
      tw1r <= 16'h5A5A; tw1i <= 16'h5A5A;
      tw2r <= 16'h5A5A; tw2i <= 16'h5A5A;
    end
  end

  // Butterfly stand-in (twiddle multiply left out so outputs stay hand-checkable).
  assign bf_o0r = bf_ar + bf_br + bf_cr + bf_dr;
  assign bf_o0i = bf_ai + bf_bi + bf_ci + bf_di;
  assign bf_o1r = bf_ar - bf_cr + bf_bi - bf_di;
  assign bf_o1i = bf_ai - bf_ci - bf_br + bf_dr;
  assign bf_o2r = bf_ar - bf_br + bf_cr - bf_dr;
  assign bf_o2i = bf_ai - bf_bi + bf_ci - bf_di;
  assign bf_o3r = bf_ar - bf_cr - bf_bi + bf_di;
  assign bf_o3i = bf_ai - bf_ci + bf_br - bf_dr;

  function automatic int scl(input int x);
`ifdef BFLY_SCALE_EN
    return (x + 2) >>> 2;
`else
    return x;
`endif
  endfunction

  function automatic int pick(input int raw, input int scaled);
`ifdef BFLY_SCALE_EN
    return scaled;
`else
    return raw;
`endif
  endfunction

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int re, input int im, input bit is_d, input int g);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_re = re;
    in_im = im;
    #1;
    while (!in_ready && t < 40) begin step(); t++; end
    check("push_in_ready", in_ready, 1);
    check("push_tw_rd_en", tw_rd_en, is_d);
    if (is_d) begin
      check("addr0_s1", tw_addr0, g % 64);
      check("addr1_s1", tw_addr1, (2 * g) % 64);
      check("addr2_s1", tw_addr2, (3 * g) % 64);
      check("addr0_s2", d2_addr0, (2 * g) % 64);
      check("addr1_s2", d2_addr1, (4 * g) % 64);
      check("addr2_s2", d2_addr2, (6 * g) % 64);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_group(input int g, input int ar, input int ai, input int br, input int bi,
                           input int cr, input int ci, input int dr, input int di, input bit stall);
    int er[4];
    int ei[4];
    int t;
    er[0] = scl(ar + br + cr + dr);  ei[0] = scl(ai + bi + ci + di);
    er[1] = scl(ar - cr + bi - di);  ei[1] = scl(ai - ci - br + dr);
    er[2] = scl(ar - br + cr - dr);  ei[2] = scl(ai - bi + ci - di);
    er[3] = scl(ar - cr - bi + di);  ei[3] = scl(ai - ci + br - dr);
    push(ar, ai, 1'b0, g);
    push(br, bi, 1'b0, g);
    push(cr, ci, 1'b0, g);
    push(dr, di, 1'b1, g);
    #1;
    check("twid_in_ready", in_ready, 0);
    check("twid_out_valid", out_valid, 0);
    step();
    check("calc_out_valid", out_valid, 0);
    check("calc_w0r", bf_w0r, 32767);
    check("calc_w0i", bf_w0i, g % 64);
    check("calc_w1i", bf_w1i, (2 * g) % 64);
    check("calc_w2i", bf_w2i, (3 * g) % 64);
    check("calc_ar", bf_ar, ar);
    check("calc_bi", bf_bi, bi);
    check("calc_cr", bf_cr, cr);
    check("calc_di", bf_di, di);
    step();
    check("emit_latency", out_valid, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (stall && k == 1) begin
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_re = 777;
        in_im = -777;
        #1;
        for (int s = 0; s < 7; s++) begin
          check("stall_valid", out_valid, 1);
          check("stall_re", out_re, er[1]);
          check("stall_im", out_im, ei[1]);
          check("stall_in_ready", in_ready, 0);
          step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
      end
      t = 0;
      while (!out_valid && t < 40) begin step(); t++; end
      check("out_valid", out_valid, 1);
      check("out_re", out_re, er[k]);
      check("out_im", out_im, ei[k]);
      check("out_last", out_last, (g == 15 && k == 3) ? 1 : 0);
      got_re[k] = out_re;
      got_im[k] = out_im;
      n_out++;
      if (out_last) n_last++;
      step();
    end
    out_ready = 1'b0;
    #1;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_re = 0;
    in_im = 0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_tw_rd_en", tw_rd_en, 0);
    check("rst_addr2", tw_addr2, 0);
    check("rst_bf_ar", bf_ar, 0);
    check("rst_bf_w0r", bf_w0r, 0);
    check("rst_out_re", out_re, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Pass-through group at g = 0.
    run_group(0, 1000, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("pass_re", got_re[k], pick(1000, 250));
      check("pass_im", got_im[k], 0);
    end
    // Distinct operands with a 7-cycle stall on out1.
    run_group(1, 1, 2, 10, 20, 100, 200, 1000, 2000, 1'b1);
    check("g1_o0r", got_re[0], pick(1111, 278));
    check("g1_o1r", got_re[1], pick(-2079, -520));
    check("g1_o1i", got_im[1], pick(792, 198));
    check("g1_o2i", got_im[2], pick(-1818, -454));
    check("g1_o3r", got_re[3], pick(1881, 470));
    // Scale rounding corner values.
    run_group(2, 1002, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    check("g2_o2r", got_re[2], pick(1002, 251));
    run_group(3, -6, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    check("g3_o0r", got_re[0], pick(-6, -1));
    check("g3_o3r", got_re[3], pick(-6, -1));
    for (int g = 4; g < 16; g++)
      run_group(g, g * 3, -g, g, 7, -g * 5, g, 11, -2 * g, 1'b0);
    check("frame_outputs", n_out, 64);
    check("frame_last_pulses", n_last, 1);
    // Group counter wrapped back to 0.
    run_group(0, 5, 6, 7, 8, 9, 10, 11, 12, 1'b0);

    // Reset after two samples of a group at g = 1.
    push(40, 41, 1'b0, 1);
    push(42, 43, 1'b0, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_bf_ar", bf_ar, 0);
    step();
    rst_n = 1'b1;
    step();
    run_group(0, -1, -2, 3, 4, -5, 6, 7, -8, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
